// File: rtl/mem_access_arbiter_if.sv
// Shared memory-port bundle: IC and DC requester signals plus main memory.
// master = arbiter view, slave = requesters and memory view.
interface mem_access_arbiter_if #(
  parameter int ADDR_WIDTH = 17,
  parameter int LEN = 32
);
  logic [1:0]            i_vis_signal;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic [LEN-1:0]        i_data;
  logic [1:0]            i_status;
  logic [1:0]            d_vis_signal;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [LEN-1:0]        d_wdata;
  logic [2:0]            d_size;
  logic [LEN-1:0]        d_data;
  logic [1:0]            d_status;
  logic [1:0]            mem_vis_signal;
  logic                  mem_vis_type;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [LEN-1:0]        mem_wdata;
  logic [2:0]            mem_size;
  logic [LEN-1:0]        mem_rdata;
  logic [1:0]            mem_status;

  modport master (
    input  i_vis_signal, i_addr,
    input  d_vis_signal, d_addr, d_wdata, d_size,
    input  mem_rdata, mem_status,
    output i_data, i_status, d_data, d_status,
    output mem_vis_signal, mem_vis_type,
    output mem_addr, mem_wdata, mem_size
  );

  modport slave (
    output i_vis_signal, i_addr,
    output d_vis_signal, d_addr, d_wdata, d_size,
    output mem_rdata, mem_status,
    input  i_data, i_status, d_data, d_status,
    input  mem_vis_signal, mem_vis_type,
    input  mem_addr, mem_wdata, mem_size
  );
endinterface

// File: rtl/mem_access_arbiter.sv
// IC/DC arbiter for the single main-memory port, DC priority with IC anti-starvation.
// Optional watchdog: define ARB_WATCHDOG_EN to abort stalled accesses after TIMEOUT cycles.
module mem_access_arbiter #(
  parameter int ADDR_WIDTH = 17,
  parameter int LEN = 32,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic rst,
  mem_access_arbiter_if.master bus
);
  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] S_MAX = SW'(MAX_D_STREAK);

  typedef enum logic [1:0] {
    IDLE, I_BUSY, D_BUSY, DONE
  } state_t;

  state_t state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [1:0] vis_q, vis_d;
  logic type_q, type_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN-1:0] wdata_q, wdata_d;
  logic [2:0] size_q, size_d;
  logic [LEN-1:0] i_data_q, i_data_d;
  logic [LEN-1:0] d_data_q, d_data_d;
  logic [1:0] i_stat_q, i_stat_d;
  logic [1:0] d_stat_q, d_stat_d;

  logic i_req, d_req, d_win, wd_hit;

  assign i_req = bus.i_vis_signal == 2'b01;
  assign d_req = (bus.d_vis_signal == 2'b01) ||
                 (bus.d_vis_signal == 2'b10);
  assign d_win = d_req && !(i_req && streak_q == S_MAX);

`ifdef ARB_WATCHDOG_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wd_q, wd_d;

  assign wd_hit = wd_q == WW'(TIMEOUT - 1);

  // cycles spent waiting on memory in the current transaction
  always_comb begin
    wd_d = '0;
    if (state_q == I_BUSY || state_q == D_BUSY)
      wd_d = wd_q + 1'b1;
  end

  // watchdog counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wd_q <= '0;
    else     wd_q <= wd_d;
  end
`else
  // never fires: without the watchdog the arbiter waits indefinitely
  assign wd_hit = TIMEOUT < 0;
`endif

  // next state, grant latching, completion routing and streak tracking
  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    vis_d    = vis_q;
    type_d   = type_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    size_d   = size_q;
    i_data_d = i_data_q;
    d_data_d = d_data_q;
    i_stat_d = i_req ? 2'b01 : 2'b00;
    d_stat_d = d_req ? 2'b01 : 2'b00;
    unique case (state_q)
      IDLE: begin
        if (d_win) begin
          state_d = D_BUSY;
          vis_d   = bus.d_vis_signal;
          type_d  = 1'b1;
          addr_d  = bus.d_addr;
          wdata_d = bus.d_wdata;
          size_d  = bus.d_size;
        end else if (i_req) begin
          state_d = I_BUSY;
          vis_d   = 2'b01;
          type_d  = 1'b0;
          addr_d  = bus.i_addr;
          size_d  = 3'b010;
        end
      end
      I_BUSY: begin
        i_stat_d = 2'b01;
        if (bus.mem_status == 2'b10) begin
          i_data_d = bus.mem_rdata;
          i_stat_d = 2'b10;
          vis_d    = 2'b00;
          state_d  = DONE;
        end else if (wd_hit) begin
          i_stat_d = 2'b11;
          vis_d    = 2'b00;
          state_d  = DONE;
        end
      end
      D_BUSY: begin
        d_stat_d = 2'b01;
        if (bus.mem_status == 2'b11) begin
          d_data_d = bus.mem_rdata;
          d_stat_d = 2'b10;
          vis_d    = 2'b00;
          state_d  = DONE;
        end else if (wd_hit) begin
          d_stat_d = 2'b11;
          vis_d    = 2'b00;
          state_d  = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (!i_req)
      streak_d = '0;
    else if (state_q == IDLE)
      streak_d = !d_win ? '0 :
                 (streak_q == S_MAX) ? streak_q :
                 streak_q + 1'b1;
  end

  // state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      streak_q <= '0;
      vis_q    <= 2'b00;
      type_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      size_q   <= 3'b010;
      i_data_q <= '0;
      d_data_q <= '0;
      i_stat_q <= 2'b00;
      d_stat_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      vis_q    <= vis_d;
      type_q   <= type_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      size_q   <= size_d;
      i_data_q <= i_data_d;
      d_data_q <= d_data_d;
      i_stat_q <= i_stat_d;
      d_stat_q <= d_stat_d;
    end
  end

  assign bus.mem_vis_signal = vis_q;
  assign bus.mem_vis_type   = type_q;
  assign bus.mem_addr       = addr_q;
  assign bus.mem_wdata      = wdata_q;
  assign bus.mem_size       = size_q;
  assign bus.i_data         = i_data_q;
  assign bus.i_status       = i_stat_q;
  assign bus.d_data         = d_data_q;
  assign bus.d_status       = d_stat_q;
endmodule
